// File: rtl/sw_btn_dev_in.sv
// Switch/button input peripheral: synchronises and debounces 8 switches and 4 buttons,
// latches press events, counts presses and returns a status word on a CPU read strobe.
module sw_btn_dev_in #(
  parameter int DEB_CYCLES = 1000,
  parameter int DEB_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        GPIOe0000000_re,
  input  logic [7:0]  SW,
  input  logic [3:0]  BTN,
  output logic [31:0] Peripheral_out,
  output logic        irq
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [11:0]      sync1_q, sync2_q;
  logic [11:0]      stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q [12];
  logic [DEB_W-1:0] cnt_d [12];
  logic [3:0]       btn_dly_q;
  logic [3:0]       btn_rise;
  logic [3:0]       flag_q, flag_d;
  logic [15:0]      count_q, count_d;
  logic [2:0]       rise_cnt;
  logic [31:0]      out_q, out_d;
  logic [31:0]      status;
  logic             irq_q, irq_d;

  // Each bit must disagree with its stable value for DEB_CYCLES consecutive cycles to flip.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 12; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    btn_rise = stable_q[11:8] & ~btn_dly_q;
    rise_cnt = {2'b00, btn_rise[0]} + {2'b00, btn_rise[1]}
             + {2'b00, btn_rise[2]} + {2'b00, btn_rise[3]};
    // A new press in the same cycle as a read keeps its flag set.
    flag_d   = (flag_q & ~{4{GPIOe0000000_re}}) | btn_rise;
    count_d  = count_q + {13'd0, rise_cnt};
    status   = {count_q, flag_q, stable_q[11:8], stable_q[7:0]};
    out_d    = GPIOe0000000_re ? status : out_q;
    irq_d    = |flag_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      for (int i = 0; i < 12; i++) begin
        cnt_q[i] <= '0;
      end
      btn_dly_q <= '0;
      flag_q    <= '0;
      count_q   <= '0;
      out_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= {BTN, SW};
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      for (int i = 0; i < 12; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      btn_dly_q <= stable_q[11:8];
      flag_q    <= flag_d;
      count_q   <= count_d;
      out_q     <= out_d;
      irq_q     <= irq_d;
    end
  end

  assign Peripheral_out = out_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_sw_btn_dev_in.sv
// Self-checking bench for sw_btn_dev_in: directed steps, randomized press/glitch episodes
// against an abstract press model, and a second fast-debounce instance for count wrap.
module tb_sw_btn_dev_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, re2;
  logic [7:0]  sw, sw2;
  logic [3:0]  btn, btn2;
  logic [31:0] out, out2;
  logic        irq, irq2;

  int tests = 0;
  int fails = 0;

  logic [7:0]  m_sw;
  logic [3:0]  m_btn, m_flags;
  logic [15:0] m_count, m2_count;

  sw_btn_dev_in #(.DEB_CYCLES(4), .DEB_W(20)) dut (
    .clk(clk), .rst(rst), .GPIOe0000000_re(re), .SW(sw), .BTN(btn),
    .Peripheral_out(out), .irq(irq)
  );

  sw_btn_dev_in #(.DEB_CYCLES(1), .DEB_W(4)) dut2 (
    .clk(clk), .rst(rst), .GPIOe0000000_re(re2), .SW(sw2), .BTN(btn2),
    .Peripheral_out(out2), .irq(irq2)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [3:0] b, input int n);
    sw  = s;
    btn = b;
    repeat (n) step();
  endtask

  task automatic readWord();
    re = 1'b1;
    step();
    re = 1'b0;
  endtask

  task automatic readWord2();
    re2 = 1'b1;
    step();
    re2 = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelWord();
    return {m_count, m_flags, m_btn, m_sw};
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] nsw;
    logic [3:0] nbtn, rises;

    rst = 1'b0; re = 1'b0; re2 = 1'b0;
    sw = 8'hFF; btn = 4'hF; sw2 = 8'h00; btn2 = 4'h0;
    repeat (3) step();
    checkOutput("reset_out", out, 32'h0);
    checkOutput("reset_irq", irq, 1'b0);
    checkOutput("reset_out2", out2, 32'h0);

    // Inputs held high through reset only appear after the debounce delay.
    rst = 1'b1;
    applyStimulus(8'hFF, 4'hF, 5);
    readWord();
    checkOutput("rel_early", out, 32'h0000_0000);
    readWord();
    checkOutput("rel_stable", out, 32'h0000_0FFF);
    checkOutput("rel_irq_set", irq, 1'b1);
    readWord();
    checkOutput("rel_flags", out, 32'h0004_FFFF);
    checkOutput("rel_irq_clr", irq, 1'b0);
    applyStimulus(8'h00, 4'h0, 10);

    applyStimulus(8'hA5, 4'h0, 5);
    readWord();
    checkOutput("sw_early", out, 32'h0004_0000);
    readWord();
    checkOutput("sw_stable", out, 32'h0004_00A5);

    applyStimulus(8'hA5, 4'h1, 3);
    checkOutput("glitch_irq_a", irq, 1'b0);
    applyStimulus(8'hA5, 4'h0, 10);
    checkOutput("glitch_irq_b", irq, 1'b0);
    readWord();
    checkOutput("glitch_word", out, 32'h0004_00A5);

    applyStimulus(8'hA5, 4'h4, 10);
    checkOutput("press_irq", irq, 1'b1);
    readWord();
    checkOutput("press_read1", out, 32'h0005_44A5);
    checkOutput("press_irq_clr", irq, 1'b0);
    readWord();
    checkOutput("press_read2", out, 32'h0005_04A5);
    applyStimulus(8'hA5, 4'h0, 10);

    // Read lands on the same edge the flag sets.
    applyStimulus(8'hA5, 4'h2, 6);
    readWord();
    checkOutput("coll_snap", out, 32'h0005_02A5);
    checkOutput("coll_irq", irq, 1'b1);
    readWord();
    checkOutput("coll_next", out, 32'h0006_22A5);
    checkOutput("coll_irq_clr", irq, 1'b0);
    applyStimulus(8'hA5, 4'h0, 10);

    m_sw = 8'hA5; m_btn = 4'h0; m_flags = 4'h0; m_count = 16'd6;
    for (int e = 0; e < 40; e++) begin
      nsw  = 8'($urandom);
      nbtn = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(nsw, nbtn, $urandom_range(1, 3));
        applyStimulus(m_sw, m_btn, 3);
        checkOutput("rand_glitch_irq", irq, |m_flags);
      end else begin
        applyStimulus(nsw, nbtn, $urandom_range(8, 12));
        rises   = nbtn & ~m_btn;
        m_flags = m_flags | rises;
        m_count = m_count + 16'($countones(rises));
        m_sw    = nsw;
        m_btn   = nbtn;
      end
      if ($urandom_range(0, 1) == 1) begin
        checkOutput("rand_irq_pre", irq, |m_flags);
        readWord();
        checkOutput("rand_read", out, modelWord());
        m_flags = 4'h0;
        checkOutput("rand_irq_post", irq, 1'b0);
      end
    end

    // Reset asserted in the middle of a read and a debounce.
    applyStimulus(8'h3C, 4'h1, 3);
    re = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out", out, 32'h0);
    checkOutput("midrst_irq", irq, 1'b0);
    re = 1'b0;
    rst = 1'b1;
    applyStimulus(8'h00, 4'h0, 10);
    readWord();
    checkOutput("midrst_read", out, 32'h0);
    checkOutput("midrst_irq2", irq, 1'b0);

    m2_count = 16'd0;
    for (int k = 0; k < 16383; k++) begin
      btn2 = 4'hF; step();
      btn2 = 4'h0; step();
      m2_count = m2_count + 16'd4;
    end
    for (int k = 0; k < 3; k++) begin
      btn2 = 4'h1; step();
      btn2 = 4'h0; step();
      m2_count = m2_count + 16'd1;
    end
    repeat (5) step();
    checkOutput("wrap_irq", irq2, 1'b1);
    readWord2();
    checkOutput("wrap_full", out2, {m2_count, 4'hF, 4'h0, 8'h00});
    btn2 = 4'hF; step();
    btn2 = 4'h0; step();
    m2_count = m2_count + 16'd4;
    repeat (5) step();
    readWord2();
    checkOutput("wrap_after", out2, {m2_count, 4'hF, 4'h0, 8'h00});
    checkOutput("wrap_value", {16'h0, m2_count}, 32'h0000_0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_btn_dev_in.md
Name: sw_btn_dev_in

Overview:
- CPU-read input peripheral: the inbound counterpart of the LED/GPIO output device.
- Samples 8 slide switches and 4 push buttons and synchronises and debounces them.
- Latches button-press events and counts presses.
- Presents a 32-bit status word to the CPU bus, captured on a read strobe from the address decoder (0xE0000000 region). Raises a level interrupt while unread presses exist.

Parameters:
DEB_CYCLES, 1000, number of consecutive cycles a synchronised input must differ from its debounced value before the debounced value changes (legal range 1..2^DEB_W-1)
DEB_W, 20, width of each per-bit debounce counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
GPIOe0000000_re  input  1  one-cycle read strobe from address decoder
SW  input  8  raw switch levels, asynchronous to clk
BTN  input  4  raw button levels, asynchronous to clk, 1 = pressed
Peripheral_out  output  32  registered status word to CPU read mux
irq  output  1  registered interrupt, high while any press flag set

Behaviour:
- Reset: rst low asynchronously clears all state: sync flops, debounced values, debounce counters, press flags, press count, Peripheral_out=0, irq=0. A switch held high through reset appears only after the normal debounce delay.
- Synchroniser: two flops per raw bit (12 bits). sync value lags raw by 2 cycles.
- Debounce, independent per bit, 12 counters:
  - sync == stable -> counter <= 0.
  - sync != stable and counter < DEB_CYCLES-1 -> counter++.
  - sync != stable and counter == DEB_CYCLES-1 -> stable <= sync, counter <= 0.
  - Raw step to stable change = 2 + DEB_CYCLES cycles.
  - Any glitch shorter than DEB_CYCLES sync cycles is rejected, and the counter restarts from 0.
- Rise detect: btn_rise[i] = stable_btn[i] & ~stable_btn_d[i], one cycle wide. Button releases are ignored.
- Press flags btn_flag[3:0]:
  - Set on btn_rise.
  - Cleared on the edge where GPIOe0000000_re = 1.
  - Set and clear on the same bit in the same cycle -> flag stays 1 (set wins).
- Press count, 16 bits:
  - Adds popcount(btn_rise), range 0..4, every cycle.
  - Wraps modulo 2^16 (0xFFFF + 1 = 0x0000). Never cleared by reads.
- Status word, computed from current-cycle register values (pre-update):
  - [7:0] stable_sw
  - [11:8] stable_btn
  - [15:12] btn_flag
  - [31:16] press_count
- Read:
  - On the rising edge where re = 1, Peripheral_out <= status word. Data is valid from the next cycle, so read latency is 1 cycle.
  - Peripheral_out holds its value until the next read.
  - Back-to-back reads on consecutive cycles are legal, and each captures fresh state. A rise coinciding with a read is not in that snapshot; it appears in the following read.
- irq <= |btn_flag_next, i.e. 1 cycle after a flag sets. It drops the cycle after the clearing read unless a flag was re-set.
- Reset asserted mid-debounce or mid-read: everything is cleared, and no partial update is visible after release.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=0 with SW=0xFF, BTN=0xF -> Peripheral_out=0x00000000, irq=0. Release with DEB_CYCLES=4 -> stable_sw=0xFF after 6 cycles.
- Switch debounce (DEB_CYCLES=4): SW 0x00->0xA5 at cycle 0, read at cycle 6 -> Peripheral_out[7:0]=0xA5. Read at cycle 5 -> 0x00.
- Glitch rejection: BTN[0] high for 3 cycles then low (DEB_CYCLES=4) -> stable_btn, flag and count stay 0, and irq stays 0.
- Press and clear: BTN[2] held 10 cycles -> irq=1.
  - First read returns [11:8]=0x4, [15:12]=0x4, [31:16]=0x0001.
  - irq=0 the cycle after.
  - Second read returns [15:12]=0x0, count still 0x0001.
- Set/clear collision: btn_rise[1] in the same cycle as re=1 -> snapshot [15:12]=0x0, flag remains 1, irq stays 1. Next read shows [15:12]=0x2.
- Count wrap: preload via 0xFFFF presses (or force), then BTN[3:0] rise simultaneously -> count=0x0003.
